link_control: RTL
=================

// Module: link_control
// PURPOSE
//  Game-loop sequencer driving the character/map state-signal handshake. Issues init, idle,
//  reg_action, apply_action, draw_map, draw strobes to link_char and the map renderer.
//  Consumes their map_done/draw_done replies. Paces one update per frame tick.
//  Sits between top-level input sync and the character/map/VGA datapath.
// PARAMETERS
//  FRAME_CYCLES   833333  clocks per game frame (50 MHz / 60 Hz); sim uses 64
//  CHECK_CYCLES   2       cycles reserved for collision_detector to settle before apply
//  TIMEOUT        131071  max cycles to wait for any *_done before abort to INIT
// PORTS
//  clock          in   1   system clock
//  reset          in   1   synchronous, active-high reset
//  pause          in   1   hold in IDLE while high (level, pre-synchronised)
//  map_done       in   1   map renderer finished (level, held until draw_map drops)
//  draw_done      in   1   link_char finished sprite draw (level, held until draw drops)
//  init           out  1   one-cycle pulse: character/map initialise
//  idle           out  1   high while waiting for frame tick
//  reg_action     out  1   one-cycle pulse: latch user command
//  apply_action   out  1   one-cycle pulse: commit move (collision already valid)
//  draw_map       out  1   high while map redraw in progress
//  draw           out  1   high while character sprite draw in progress
//  frame_overrun  out  1   one-cycle pulse: tick arrived while a tick was already pending
//  timeout_err    out  1   one-cycle pulse: a *_done wait exceeded TIMEOUT
// BEHAVIOUR
//  - All outputs registered; reset forces all outputs 0, state=BOOT, counters 0, pending=0.
//  - States/transitions (one per clock edge unless noted):
//    BOOT  -> INIT unconditionally.
//    INIT  (init=1, 1 cycle) -> IDLE.
//    IDLE  (idle=1) -> REG when (pending|tick) & !pause; consumes pending.
//    REG   (reg_action=1, 1 cycle) -> CHECK.
//    CHECK (all outs 0, CHECK_CYCLES cycles) -> APPLY.
//    APPLY (apply_action=1, 1 cycle) -> MAP.
//    MAP   (draw_map=1) -> LINK on the edge after map_done sampled 1.
//    LINK  (draw=1) -> IDLE on the edge after draw_done sampled 1.
//  - Outputs reflect the state entered at the same edge (Moore, registered).
//    E.g. draw=1 exactly for LINK-state cycles.
//  - Done inputs are sampled only in their own state.
//    A stale done still high on entry to MAP/LINK is ignored.
//    Required: the done input must be low in the first cycle of MAP/LINK.
//    Done seen high in that first cycle is treated as stale.
//  - frame timer: free-running 20-bit counter, wraps at FRAME_CYCLES-1.
//    tick=1 on the wrap cycle. Unaffected by pause; cleared only by reset.
//  - tick outside IDLE sets pending. tick while pending=1 pulses frame_overrun.
//    pending stays 1 (max one queued frame). tick in IDLE while pause=1 sets pending.
//  - Wait counter clears on MAP/LINK entry and increments each cycle there.
//    Reaching TIMEOUT pulses timeout_err and goes to INIT; pending is cleared.
//  - pause has no effect outside IDLE; a frame in progress always completes.
//  - reset mid-state: next edge state=BOOT, all outputs 0, no partial pulse completes.
//  - Never two strobes high in the same cycle (one-hot output invariant).
// STRUCTURE
//  - control_defs.vh: state codes BOOT..LINK (3-bit), shared with debug/HEX display logic.
//  - Sub-module frame_timer (clock, reset, tick; param FRAME_CYCLES).
//  - FSM, pending flag and wait counter live in link_control.
// TESTING (FRAME_CYCLES=64, CHECK_CYCLES=2, TIMEOUT=300)
//  1 reset 3 cycles then release -> BOOT, then init=1 1 cycle, then idle=1 until first tick.
//    All other outs 0.
//  2 tick in IDLE -> reg_action, 2 quiet cycles, apply_action, then draw_map.
//    All strobes 1 cycle each.
//  3 map_done=1 after 20 cycles; draw_done=1 after 256 -> draw_map/draw drop the edge after
//    each done; idle=1 after.
//  4 pause=1 across 3 ticks -> stays IDLE, frame_overrun pulses at 2nd and 3rd tick.
//    pause=0 -> REG next edge.
//  5 withhold draw_done -> timeout_err pulse at wait count 300, then init=1, then IDLE.
//  6 reset asserted in LINK -> draw=0 next edge, BOOT; assert one-hot outputs every cycle.

Source files
------------

// File: rtl/link_control_pkg.sv
// Shared definitions for the game-loop sequencer: state codes, strobe bundle
// and the state-to-strobe decode used by the registered output stage.
package link_control_pkg;

    localparam int TIMER_WIDTH = 20;

    // 3-bit codes kept stable so debug/HEX display logic can decode them.
    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_INIT  = 3'd1,
        ST_IDLE  = 3'd2,
        ST_REG   = 3'd3,
        ST_CHECK = 3'd4,
        ST_APPLY = 3'd5,
        ST_MAP   = 3'd6,
        ST_LINK  = 3'd7
    } state_t;

    typedef struct packed {
        logic init;
        logic idle;
        logic reg_action;
        logic apply_action;
        logic draw_map;
        logic draw;
    } strobes_t;

    function automatic strobes_t decode_state(input state_t s);
        strobes_t o;
        o = '0;
        case (s)
            ST_INIT:  o.init         = 1'b1;
            ST_IDLE:  o.idle         = 1'b1;
            ST_REG:   o.reg_action   = 1'b1;
            ST_APPLY: o.apply_action = 1'b1;
            ST_MAP:   o.draw_map     = 1'b1;
            ST_LINK:  o.draw         = 1'b1;
            default:  o              = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/link_control_if.sv
// Handshake bundle between the sequencer and the character/map datapath.
interface link_control_if;
    logic pause;
    logic map_done;
    logic draw_done;
    logic init;
    logic idle;
    logic reg_action;
    logic apply_action;
    logic draw_map;
    logic draw;
    logic frame_overrun;
    logic timeout_err;

    modport master (
        input  pause, map_done, draw_done,
        output init, idle, reg_action, apply_action, draw_map, draw,
               frame_overrun, timeout_err
    );

    modport slave (
        output pause, map_done, draw_done,
        input  init, idle, reg_action, apply_action, draw_map, draw,
               frame_overrun, timeout_err
    );
endinterface

// File: rtl/link_control_frame_timer.sv
// Free-running frame pacer: tick is high for the single cycle the counter wraps.
module frame_timer
    import link_control_pkg::*;
#(
    parameter int FRAME_CYCLES = 833333
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam logic [TIMER_WIDTH-1:0] LAST = TIMER_WIDTH'(FRAME_CYCLES - 1);

    logic [TIMER_WIDTH-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
        end else if (count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tick = (count_reg == LAST);
endmodule

// File: rtl/link_control.sv
// Game-loop sequencer: paces one init/reg/check/apply/map/draw pass per frame
// tick, queues at most one late frame, and aborts stuck renderer waits.
module link_control
    import link_control_pkg::*;
#(
    parameter int FRAME_CYCLES = 833333,
    parameter int CHECK_CYCLES = 2,
    parameter int TIMEOUT      = 131071
) (
    input  logic           clock,
    input  logic           reset,
    link_control_if.master lnk
);
    localparam int CHECK_W = $clog2(CHECK_CYCLES + 1);
    localparam int WAIT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CHECK_W-1:0] CHECK_LAST = CHECK_W'(CHECK_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

    logic tick;

    state_t             state_reg, state_next;
    logic               pending_reg, pending_next;
    logic [CHECK_W-1:0] check_cnt_reg, check_cnt_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    strobes_t           strobes_reg;
    logic               overrun_reg, overrun_next;
    logic               timeout_reg, timeout_next;

    frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_frame_timer (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        state_next     = state_reg;
        pending_next   = pending_reg;
        check_cnt_next = check_cnt_reg;
        wait_cnt_next  = wait_cnt_reg;
        timeout_next   = 1'b0;
        overrun_next   = tick & pending_reg;
        if (tick) begin
            pending_next = 1'b1;
        end
        case (state_reg)
            ST_BOOT: state_next = ST_INIT;
            ST_INIT: state_next = ST_IDLE;
            ST_IDLE: begin
                if ((pending_reg | tick) & ~lnk.pause) begin
                    state_next   = ST_REG;
                    pending_next = 1'b0;
                end
            end
            ST_REG: begin
                state_next     = ST_CHECK;
                check_cnt_next = '0;
            end
            ST_CHECK: begin
                if (check_cnt_reg == CHECK_LAST) begin
                    state_next = ST_APPLY;
                end else begin
                    check_cnt_next = check_cnt_reg + 1'b1;
                end
            end
            ST_APPLY: begin
                state_next    = ST_MAP;
                wait_cnt_next = '0;
            end
            // A done seen while the wait count is still zero is left over from
            // the previous pass and is ignored.
            ST_MAP, ST_LINK: begin
                if (((state_reg == ST_MAP) ? lnk.map_done : lnk.draw_done)
                        && (wait_cnt_reg != '0)) begin
                    state_next    = (state_reg == ST_MAP) ? ST_LINK : ST_IDLE;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    // Abort re-enters through BOOT so timeout_err and init
                    // land on separate cycles.
                    state_next    = ST_BOOT;
                    timeout_next  = 1'b1;
                    pending_next  = 1'b0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_BOOT;
            pending_reg   <= 1'b0;
            check_cnt_reg <= '0;
            wait_cnt_reg  <= '0;
            strobes_reg   <= '0;
            overrun_reg   <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            check_cnt_reg <= check_cnt_next;
            wait_cnt_reg  <= wait_cnt_next;
            strobes_reg   <= decode_state(state_next);
            overrun_reg   <= overrun_next;
            timeout_reg   <= timeout_next;
        end
    end

    assign lnk.init          = strobes_reg.init;
    assign lnk.idle          = strobes_reg.idle;
    assign lnk.reg_action    = strobes_reg.reg_action;
    assign lnk.apply_action  = strobes_reg.apply_action;
    assign lnk.draw_map      = strobes_reg.draw_map;
    assign lnk.draw          = strobes_reg.draw;
    assign lnk.frame_overrun = overrun_reg;
    assign lnk.timeout_err   = timeout_reg;
endmodule
